// File: rtl/xpmwrap_sdpram_ctrl_pkg.sv
// rtl/xpmwrap_sdpram_ctrl_pkg.sv - shared constants and width helpers for the sdpram controller
package xpmwrap_sdpram_ctrl_pkg;

    localparam int READ_LATENCY      = 2;
    localparam int NUM_WR            = 2;
    localparam int RSP_DEPTH_DEFAULT = 4;

    function automatic int strb_width(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    // Counter must hold the value DEPTH itself, hence depth+1 states.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef logic [$clog2(RSP_DEPTH_DEFAULT + 1)-1:0] credit_t;

endpackage

// File: rtl/xpmwrap_sdpram_ctrl_if.sv
// rtl/xpmwrap_sdpram_ctrl_if.sv - write/read request and read response bundle of the sdpram controller
interface xpmwrap_sdpram_ctrl_if
    import xpmwrap_sdpram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
);
    localparam int SW = strb_width(DATA_WIDTH, BYTE_WIDTH);

    logic [NUM_WR-1:0]            wr_valid;
    logic [NUM_WR-1:0]            wr_ready;
    logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic [NUM_WR*SW-1:0]         wr_strb;
    logic                         rd_req_valid;
    logic                         rd_req_ready;
    logic [ADDR_WIDTH-1:0]        rd_req_addr;
    logic                         rd_rsp_valid;
    logic                         rd_rsp_ready;
    logic [DATA_WIDTH-1:0]        rd_rsp_data;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_strb, rd_req_valid, rd_req_addr, rd_rsp_ready,
        input  wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_strb, rd_req_valid, rd_req_addr, rd_rsp_ready,
        output wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data
    );

endinterface

// File: rtl/xpmwrap_sync_fifo.sv
// rtl/xpmwrap_sync_fifo.sv - synchronous FIFO with registered head-of-queue output
module xpmwrap_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [CW-1:0]    count_nxt;
    logic             do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign do_pop = pop & ~empty;

    always_comb begin
        rd_ptr_nxt = do_pop ? inc(rd_ptr_q) : rd_ptr_q;
        count_nxt  = count + CW'(push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    // rd_data always shows the next head; a push landing in the head slot bypasses the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            rd_data  <= '0;
        end else begin
            if (push) wr_ptr_q <= inc(wr_ptr_q);
            rd_ptr_q <= rd_ptr_nxt;
            count    <= count_nxt;
            if (count_nxt != '0)
                rd_data <= (push && (rd_ptr_nxt == wr_ptr_q)) ? push_data : mem_q[rd_ptr_nxt];
        end
    end

endmodule

// File: rtl/xpmwrap_sdpram_ctrl.sv
// rtl/xpmwrap_sdpram_ctrl.sv - round-robin write / credited read controller for one sdpram instance
// Optional same-address read stall: XPMWRAP_SDPRAM_CTRL_HAZARD_EN.
module xpmwrap_sdpram_ctrl
    import xpmwrap_sdpram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    xpmwrap_sdpram_ctrl_if.slave  bus,
    output logic                  mem_ena,
    output logic [DATA_WIDTH/BYTE_WIDTH-1:0] mem_wea,
    output logic [ADDR_WIDTH-1:0] mem_addra,
    output logic [DATA_WIDTH-1:0] mem_dina,
    output logic                  mem_enb,
    output logic                  mem_regceb,
    output logic [ADDR_WIDTH-1:0] mem_addrb,
    input  logic [DATA_WIDTH-1:0] mem_doutb
);

    localparam int SW = strb_width(DATA_WIDTH, BYTE_WIDTH);
    localparam int CW = credit_width(RSP_DEPTH);

    logic                    run_q;
    logic                    rr_ptr_q;
    logic [READ_LATENCY-1:0] vld_q;
    logic [NUM_WR-1:0]       grant;
    logic                    gidx;
    logic                    accept, pop, credit_ok, hazard;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_full, fifo_empty;
    int                      outstanding;

    // run_q doubles as regceb and keeps every combinational grant low while in reset.
    always_comb begin
        grant[0] = run_q & bus.wr_valid[0] & (~bus.wr_valid[1] | ~rr_ptr_q);
        grant[1] = run_q & bus.wr_valid[1] & (~bus.wr_valid[0] |  rr_ptr_q);
    end

    assign gidx         = grant[1];
    assign bus.wr_ready = grant;
    assign mem_ena      = |grant;

    always_comb begin
        mem_wea   = '0;
        mem_addra = '0;
        mem_dina  = '0;
        if (mem_ena) begin
            mem_wea   = gidx ? bus.wr_strb[2*SW-1:SW]                 : bus.wr_strb[SW-1:0];
            mem_addra = gidx ? bus.wr_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.wr_addr[ADDR_WIDTH-1:0];
            mem_dina  = gidx ? bus.wr_data[2*DATA_WIDTH-1:DATA_WIDTH] : bus.wr_data[DATA_WIDTH-1:0];
        end
    end

`ifdef XPMWRAP_SDPRAM_CTRL_HAZARD_EN
    assign hazard = mem_ena && (mem_addra == bus.rd_req_addr);
`else
    assign hazard = 1'b0;
`endif

    // Reads in the latency pipe plus buffered words must leave a free slot for a new read.
    always_comb outstanding = $countones(vld_q) + int'(fifo_count) - int'(pop);

    assign pop              = bus.rd_rsp_valid & bus.rd_rsp_ready;
    assign credit_ok        = run_q & (outstanding < RSP_DEPTH);
    assign bus.rd_req_ready = credit_ok & ~hazard;
    assign accept           = bus.rd_req_valid & bus.rd_req_ready;
    assign mem_enb          = accept;
    assign mem_addrb        = accept ? bus.rd_req_addr : '0;
    assign mem_regceb       = run_q;
    assign bus.rd_rsp_valid = ~fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            rr_ptr_q <= 1'b0;
            vld_q    <= '0;
        end else begin
            run_q <= 1'b1;
            if (mem_ena) rr_ptr_q <= ~gidx;
            vld_q <= {vld_q[READ_LATENCY-2:0], accept};
        end
    end

    xpmwrap_sync_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_q[READ_LATENCY-1]),
        .push_data (mem_doutb),
        .pop       (pop),
        .rd_data   (bus.rd_rsp_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assert property (@(posedge clk) disable iff (!rst_n) !(vld_q[READ_LATENCY-1] && fifo_full));

endmodule

// File: tb/tb_xpmwrap_sdpram_ctrl.sv
// tb/tb_xpmwrap_sdpram_ctrl.sv - randomized bench for xpmwrap_sdpram_ctrl against a queue-based model
module tb_xpmwrap_sdpram_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mem_ena, mem_enb, mem_regceb;
    logic [3:0]  mem_wea;
    logic [5:0]  mem_addra, mem_addrb;
    logic [31:0] mem_dina, mem_doutb;

    xpmwrap_sdpram_ctrl_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .BYTE_WIDTH(8)) bus ();

    xpmwrap_sdpram_ctrl #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (32),
        .BYTE_WIDTH (8),
        .RSP_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .mem_ena    (mem_ena),
        .mem_wea    (mem_wea),
        .mem_addra  (mem_addra),
        .mem_dina   (mem_dina),
        .mem_enb    (mem_enb),
        .mem_regceb (mem_regceb),
        .mem_addrb  (mem_addrb),
        .mem_doutb  (mem_doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the byte-write memory: read-first, two-stage output.
    logic [31:0] tb_mem [64];
    logic [31:0] b_stage;
    always @(posedge clk) begin
        if (mem_ena)
            for (int b = 0; b < 4; b++)
                if (mem_wea[b]) tb_mem[mem_addra][8*b +: 8] <= mem_dina[8*b +: 8];
        if (mem_enb)    b_stage   <= tb_mem[mem_addrb];
        if (mem_regceb) mem_doutb <= b_stage;
    end

    typedef struct {
        logic [31:0] d;
        int          t;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] ref_mem [64];
    logic        last_win;
    logic [31:0] last_data;
    logic        last_acc;
    int          cyc;
    int          n_chk;
    int          n_pass;
    int          n_acc;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic idle();
        bus.wr_valid     = 2'b00;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        bus.wr_strb      = '0;
        bus.rd_req_valid = 1'b0;
        bus.rd_req_addr  = '0;
        bus.rd_rsp_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n            = 1'b0;
        bus.wr_valid     = 2'b11;
        bus.wr_strb      = 8'hff;
        bus.wr_addr      = 12'h145;
        bus.wr_data      = 64'h1234_5678_9abc_def0;
        bus.rd_req_valid = 1'b1;
        bus.rd_req_addr  = 6'd7;
        bus.rd_rsp_ready = 1'b1;
        #1;
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_rd_req_ready", bus.rd_req_ready, 0);
        chk("rst_rd_rsp_valid", bus.rd_rsp_valid, 0);
        chk("rst_rd_rsp_data", bus.rd_rsp_data, 0);
        chk("rst_mem_outputs", {mem_ena, mem_wea, mem_addra, mem_dina, mem_enb, mem_regceb, mem_addrb}, 0);
        exp_q.delete();
        last_win  = 1'b1;
        last_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle();
    endtask

    // One clock: drive at negedge, check outputs 1ns later against the model, then update the model.
    task automatic step(input logic [1:0] wv, input logic [11:0] wa, input logic [63:0] wd,
                        input logic [7:0] ws, input logic rv, input logic [5:0] ra, input logic rr);
        logic        w, haz, ev, erdy, pop, acc;
        logic [1:0]  eg;
        logic [5:0]  a;
        logic [31:0] d, head;
        logic [3:0]  s;
        @(negedge clk);
        bus.wr_valid     = wv;
        bus.wr_addr      = wa;
        bus.wr_data      = wd;
        bus.wr_strb      = ws;
        bus.rd_req_valid = rv;
        bus.rd_req_addr  = ra;
        bus.rd_rsp_ready = rr;
        #1;
        w  = (wv == 2'b11) ? ~last_win : wv[1];
        eg = (wv == 2'b00) ? 2'b00 : (w ? 2'b10 : 2'b01);
        a  = w ? wa[11:6]   : wa[5:0];
        d  = w ? wd[63:32]  : wd[31:0];
        s  = w ? ws[7:4]    : ws[3:0];
        chk("wr_ready", bus.wr_ready, eg);
        chk("mem_ena", mem_ena, |eg);
        chk("mem_port_a", {mem_wea, mem_addra, mem_dina}, (|eg) ? {s, a, d} : 42'd0);
`ifdef XPMWRAP_SDPRAM_CTRL_HAZARD_EN
        haz = (|eg) && (a == ra);
`else
        haz = 1'b0;
`endif
        ev   = (exp_q.size() > 0) && (exp_q[0].t <= cyc);
        pop  = ev && rr;
        erdy = !haz && ((exp_q.size() - int'(pop)) < 4);
        head = last_data;
        if (ev) head = exp_q[0].d;
        chk("rd_req_ready", bus.rd_req_ready, erdy);
        chk("rd_rsp_valid", bus.rd_rsp_valid, ev);
        chk("rd_rsp_data", bus.rd_rsp_data, head);
        last_data = head;
        if (pop) void'(exp_q.pop_front());
        acc = rv && erdy;
        chk("mem_port_b", {mem_enb, mem_addrb}, acc ? {1'b1, ra} : 7'd0);
        chk("mem_regceb", mem_regceb, 1'b1);
        if (acc) exp_q.push_back('{d: ref_mem[ra], t: cyc + 3});
        if (|eg) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            last_win = w;
        end
        last_acc = acc;
        cyc++;
    endtask

    task automatic drain(input int n);
        repeat (n) step(2'b00, '0, '0, '0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        cyc = 0;
        rst_n = 1'b0;
        idle();
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;

        do_reset();
        for (int i = 0; i < 6; i++)
            step(2'b11, 12'($urandom), {$urandom, $urandom}, 8'($urandom), 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++)
            step(2'b01, 12'($urandom), {$urandom, $urandom}, 8'($urandom), 1'b0, '0, 1'b1);
        step(2'b01, {6'd0, 6'd5}, {32'd0, 32'hAABBCCDD}, 8'h05, 1'b0, '0, 1'b1);
        step(2'b11, {6'd4, 6'd4}, {32'h1, 32'h2}, 8'h00, 1'b0, '0, 1'b1);

        for (int i = 0; i < 64; i++)
            step(2'b10, {6'(i), 6'd0}, {32'(i * 32'h11), 32'd0}, 8'hf0, 1'b0, '0, 1'b1);

        for (int i = 0; i < 8; i++) step(2'b00, '0, '0, '0, 1'b1, 6'(i), 1'b1);
        drain(6);
        chk("stream_drained", exp_q.size(), 0);

        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            step(2'b00, '0, '0, '0, 1'b1, 6'(10 + i), 1'b0);
            if (last_acc) n_acc++;
        end
        chk("bp_accepts", n_acc, 4);
        drain(10);
        chk("bp_drained", exp_q.size(), 0);

        do_reset();
        for (int i = 0; i < 3; i++) step(2'b00, '0, '0, '0, 1'b1, 6'(20 + i), 1'b0);
        do_reset();
        step(2'b00, '0, '0, '0, 1'b1, 6'd3, 1'b1);
        drain(8);
        chk("post_reset_drained", exp_q.size(), 0);

        step(2'b01, {6'd0, 6'd9}, {32'd0, 32'h12345678}, 8'h0f, 1'b1, 6'd9, 1'b1);
`ifdef XPMWRAP_SDPRAM_CTRL_HAZARD_EN
        chk("hazard_first_accept", last_acc, 0);
`else
        chk("hazard_first_accept", last_acc, 1);
`endif
        step(2'b00, '0, '0, '0, 1'b1, 6'd9, 1'b1);
        drain(6);

        for (int i = 0; i < 300; i++)
            step(2'($urandom), {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))},
                 {$urandom, $urandom}, 8'($urandom), 1'($urandom),
                 6'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        drain(10);
        chk("random_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
